// File: rtl/cw305_bridge_pkg.sv
// Shared constants for the CW305 USB register bridge: register map,
// status byte layout and the control bits of the status register.
package cw305_bridge_pkg;

   // Register map, in units of the upper USB address field
   localparam int REG_CLKSETTINGS   = 0;
   localparam int REG_USER_LED      = 1;
   localparam int REG_BRIDGE_STATUS = 2;
   localparam int REG_PROG_INSTR    = 3;
   localparam int REG_PROG_ADDRESS  = 4;
   localparam int REG_PROG_COMMIT   = 5;
   localparam int REG_HEEP_DATA     = 6;
   localparam int REG_BUILDTIME     = 7;

   // Bit positions inside O_status / REG_BRIDGE_STATUS reads
   localparam int STAT_EMPTY      = 0;
   localparam int STAT_FULL       = 1;
   localparam int STAT_OVERFLOW   = 2;
   localparam int STAT_HEEP_VALID = 3;
   localparam int STAT_COUNT_LSB  = 4;
   localparam int STAT_COUNT_W    = 4;

   // Control bits honoured on writes to REG_BRIDGE_STATUS
   localparam int CTRL_CLR_OVERFLOW = 2;
   localparam int CTRL_FLUSH        = 7;

endpackage

// File: rtl/cw305_bridge_fifo.sv
// Command FIFO between the USB register side and the program bridge.
// Pop frees a slot before push is judged, so a full FIFO accepts a push
// in the same cycle it is popped. Flush overrides both push and pop.
module cw305_bridge_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                   usb_clk,
   input  logic                   reset_i,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       wr_data,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   full,
   output logic                   empty,
   output logic                   drop,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & ~empty & ~flush;
   assign do_push = push & ~flush & (~full | do_pop);
   assign drop    = push & ~flush & full & ~do_pop;
   assign rd_data = empty ? '0 : mem[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
   // NOTE: non-blocking assignments in clocked blocks so every register
   // samples the pre-edge values of its neighbours, independent of order.
   always_ff @(posedge usb_clk or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage
   // NOTE: the array has no reset; emptiness comes from count, and rd_data
   // is masked to zero while empty, so stale contents are never visible.
   always_ff @(posedge usb_clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/cw305_reg_bridge.sv
// CW305 USB register bridge: clock/LED registers, instruction/address
// staging with a commit FIFO towards the program bridge, a status byte,
// and an optional readback shadow of a word returned by the target.
// Build option: define CW305_BRIDGE_READBACK_EN to include the readback
// shadow register (REG_HEEP_DATA, status bit 3).
module cw305_reg_bridge
   import cw305_bridge_pkg::*;
#(
   parameter int pADDR_WIDTH   = 21,
   parameter int pBYTECNT_SIZE = 7,
   parameter int pDATA_WIDTH   = 32,
   parameter int pFIFO_DEPTH   = 4
) (
   input  logic                                 usb_clk,
   input  logic                                 reset_i,
   input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
   input  logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
   input  logic [7:0]                           write_data,
   output logic [7:0]                           read_data,
   input  logic                                 reg_read,
   input  logic                                 reg_write,
   input  logic                                 reg_addrvalid,
   output logic [4:0]                           O_clksettings,
   output logic                                 O_user_led,
   output logic                                 O_cmd_valid,
   input  logic                                 I_cmd_ready,
   output logic [pDATA_WIDTH-1:0]               O_instruction,
   output logic [pDATA_WIDTH-1:0]               O_address,
   input  logic [pDATA_WIDTH-1:0]               I_heep_data,
   input  logic                                 I_heep_data_valid,
   output logic [7:0]                           O_status
);

   localparam int AW     = pADDR_WIDTH - pBYTECNT_SIZE;
   localparam int NBYTES = pDATA_WIDTH / 8;
   localparam int CW     = $clog2(pFIFO_DEPTH) + 1;

   logic                     wr_en, rd_en;
   logic                     sel_clk, sel_led, sel_status, sel_instr;
   logic                     sel_addr, sel_commit, sel_heep, last_byte;
   logic [pDATA_WIDTH-1:0]   staged_instr, staged_addr;
   logic                     fifo_push, fifo_pop, fifo_flush;
   logic                     fifo_full, fifo_empty, fifo_drop;
   logic [CW-1:0]            fifo_count;
   logic [2*pDATA_WIDTH-1:0] fifo_head;
   logic                     overflow;
   logic [pDATA_WIDTH-1:0]   heep_shadow;
   logic                     heep_valid;
   logic [7:0]               rd_byte;

   assign wr_en      = reg_addrvalid & reg_write;
   assign rd_en      = reg_addrvalid & reg_read;
   assign sel_clk    = (reg_address == AW'(REG_CLKSETTINGS));
   assign sel_led    = (reg_address == AW'(REG_USER_LED));
   assign sel_status = (reg_address == AW'(REG_BRIDGE_STATUS));
   assign sel_instr  = (reg_address == AW'(REG_PROG_INSTR));
   assign sel_addr   = (reg_address == AW'(REG_PROG_ADDRESS));
   assign sel_commit = (reg_address == AW'(REG_PROG_COMMIT));
   assign sel_heep   = (reg_address == AW'(REG_HEEP_DATA));
   assign last_byte  = (reg_bytecnt == pBYTECNT_SIZE'(NBYTES - 1));

   // Configuration and staging registers; out-of-range byte indices fall through
   always_ff @(posedge usb_clk or posedge reset_i) begin
      if (reset_i) begin
         O_clksettings <= '0;
         O_user_led    <= 1'b0;
         staged_instr  <= '0;
         staged_addr   <= '0;
      end else if (wr_en) begin
         if (sel_clk) O_clksettings <= write_data[4:0];
         if (sel_led) O_user_led    <= write_data[0];
         for (int i = 0; i < NBYTES; i++) begin
            if (reg_bytecnt == pBYTECNT_SIZE'(i)) begin
               if (sel_instr) staged_instr[i*8 +: 8] <= write_data;
               if (sel_addr)  staged_addr[i*8 +: 8]  <= write_data;
            end
         end
      end
   end

   // A flush in the same cycle as a commit discards the commit silently
   assign fifo_flush = wr_en & sel_status & write_data[CTRL_FLUSH];
   assign fifo_push  = wr_en & sel_commit & ~fifo_flush;
   assign fifo_pop   = O_cmd_valid & I_cmd_ready;

   cw305_bridge_fifo #(
      .WIDTH (2 * pDATA_WIDTH),
      .DEPTH (pFIFO_DEPTH)
   ) u_fifo (
      .usb_clk (usb_clk),
      .reset_i (reset_i),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .flush   (fifo_flush),
      .wr_data ({staged_addr, staged_instr}),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .drop    (fifo_drop),
      .count   (fifo_count)
   );

   assign O_cmd_valid   = ~fifo_empty;
   assign O_instruction = fifo_head[pDATA_WIDTH-1:0];
   assign O_address     = fifo_head[2*pDATA_WIDTH-1:pDATA_WIDTH];

   // Sticky overflow; a dropped commit outranks a same-cycle clear
   always_ff @(posedge usb_clk or posedge reset_i) begin
      if (reset_i)                                              overflow <= 1'b0;
      else if (fifo_drop)                                       overflow <= 1'b1;
      else if (wr_en && sel_status && write_data[CTRL_CLR_OVERFLOW]) overflow <= 1'b0;
   end

`ifdef CW305_BRIDGE_READBACK_EN
   // Readback shadow; a new capture outranks the clear from reading the last byte
   always_ff @(posedge usb_clk or posedge reset_i) begin
      if (reset_i) begin
         heep_shadow <= '0;
         heep_valid  <= 1'b0;
      end else if (I_heep_data_valid) begin
         heep_shadow <= I_heep_data;
         heep_valid  <= 1'b1;
      end else if (rd_en && sel_heep && last_byte) begin
         heep_valid  <= 1'b0;
      end
   end
`else
   logic unused_heep;
   assign unused_heep = ^{I_heep_data, I_heep_data_valid, last_byte};
   assign heep_shadow = '0;
   assign heep_valid  = 1'b0;
`endif

   // Status byte assembly
   always_comb begin
      O_status                                  = '0;
      O_status[STAT_EMPTY]                      = fifo_empty;
      O_status[STAT_FULL]                       = fifo_full;
      O_status[STAT_OVERFLOW]                   = overflow;
      O_status[STAT_HEEP_VALID]                 = heep_valid;
      O_status[STAT_COUNT_LSB +: STAT_COUNT_W]  = STAT_COUNT_W'(fifo_count);
   end

   // Read multiplexer; unmapped registers and BUILDTIME read as zero
   // NOTE: rd_byte gets its default first, so no path leaves it unassigned
   // and no latch is inferred.
   always_comb begin
      rd_byte = '0;
      if (sel_clk) begin
         rd_byte = {3'b000, O_clksettings};
      end else if (sel_led) begin
         rd_byte = {7'b0, O_user_led};
      end else if (sel_status) begin
         rd_byte = O_status;
      end else if (sel_instr || sel_addr || sel_heep) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (reg_bytecnt == pBYTECNT_SIZE'(i)) begin
               if (sel_instr)     rd_byte = staged_instr[i*8 +: 8];
               else if (sel_addr) rd_byte = staged_addr[i*8 +: 8];
               else               rd_byte = heep_shadow[i*8 +: 8];
            end
         end
      end
   end

   // Registered read data, zero outside a read strobe
   always_ff @(posedge usb_clk or posedge reset_i) begin
      if (reset_i)    read_data <= '0;
      else if (rd_en) read_data <= rd_byte;
      else            read_data <= '0;
   end

endmodule

// File: tb/tb_cw305_reg_bridge.sv
// Self-checking bench for cw305_reg_bridge: a queue-based reference model
// compared against the DUT every falling edge, plus literal expectations.
module tb_cw305_reg_bridge;

   localparam int AW    = 14;
   localparam int BC    = 7;
   localparam int DEPTH = 4;
`ifdef CW305_BRIDGE_READBACK_EN
   localparam bit RB_EN = 1'b1;
`else
   localparam bit RB_EN = 1'b0;
`endif

   localparam int A_CLK = 0, A_LED = 1, A_STAT = 2, A_INSTR = 3;
   localparam int A_ADDR = 4, A_COMMIT = 5, A_HEEP = 6, A_BUILD = 7;

   logic          usb_clk = 1'b0;
   logic          reset_i = 1'b1;
   logic [AW-1:0] reg_address = '0;
   logic [BC-1:0] reg_bytecnt = '0;
   logic [7:0]    write_data = '0;
   logic [7:0]    read_data;
   logic          reg_read = 1'b0, reg_write = 1'b0, reg_addrvalid = 1'b0;
   logic [4:0]    O_clksettings;
   logic          O_user_led, O_cmd_valid;
   logic          I_cmd_ready = 1'b0;
   logic [31:0]   O_instruction, O_address;
   logic [31:0]   I_heep_data = '0;
   logic          I_heep_data_valid = 1'b0;
   logic [7:0]    O_status;

   int checks = 0;
   int errors = 0;

   cw305_reg_bridge dut (
      .usb_clk           (usb_clk),
      .reset_i           (reset_i),
      .reg_address       (reg_address),
      .reg_bytecnt       (reg_bytecnt),
      .write_data        (write_data),
      .read_data         (read_data),
      .reg_read          (reg_read),
      .reg_write         (reg_write),
      .reg_addrvalid     (reg_addrvalid),
      .O_clksettings     (O_clksettings),
      .O_user_led        (O_user_led),
      .O_cmd_valid       (O_cmd_valid),
      .I_cmd_ready       (I_cmd_ready),
      .O_instruction     (O_instruction),
      .O_address         (O_address),
      .I_heep_data       (I_heep_data),
      .I_heep_data_valid (I_heep_data_valid),
      .O_status          (O_status)
   );

   always #5 usb_clk = ~usb_clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [63:0] mq[$];        // {address, instruction}, head at index 0
   logic [4:0]  m_clk = '0;
   logic        m_led = 1'b0;
   logic [31:0] m_instr = '0, m_addr = '0, m_heep = '0;
   logic        m_ovf = 1'b0, m_hv = 1'b0;
   logic [7:0]  m_rd = '0;

   function automatic logic [7:0] model_status();
      int n = mq.size();
      return {4'(n), m_hv, m_ovf, n == DEPTH, n == 0};
   endfunction

   function automatic logic [7:0] model_byte(input int a, input int bc);
      case (a)
         A_CLK:   return {3'b000, m_clk};
         A_LED:   return {7'b0, m_led};
         A_STAT:  return model_status();
         A_INSTR: return (bc < 4) ? m_instr[bc*8 +: 8] : 8'h00;
         A_ADDR:  return (bc < 4) ? m_addr[bc*8 +: 8] : 8'h00;
         A_HEEP:  return (RB_EN && bc < 4) ? m_heep[bc*8 +: 8] : 8'h00;
         default: return 8'h00;
      endcase
   endfunction

   task automatic model_step();
      bit wr, rd, flush, commit, ovf_evt;
      int a, bc;
      logic [7:0] nrd;
      a   = int'(reg_address);
      bc  = int'(reg_bytecnt);
      wr  = reg_addrvalid && reg_write;
      rd  = reg_addrvalid && reg_read;
      nrd = rd ? model_byte(a, bc) : 8'h00;
      flush  = wr && a == A_STAT && write_data[7];
      commit = wr && a == A_COMMIT;
      ovf_evt = 1'b0;
      if (flush) mq.delete();
      else begin
         if (mq.size() > 0 && I_cmd_ready) void'(mq.pop_front());
         if (commit) begin
            if (mq.size() < DEPTH) mq.push_back({m_addr, m_instr});
            else ovf_evt = 1'b1;
         end
      end
      if (ovf_evt) m_ovf = 1'b1;
      else if (wr && a == A_STAT && write_data[2]) m_ovf = 1'b0;
      if (RB_EN) begin
         if (I_heep_data_valid) begin
            m_heep = I_heep_data;
            m_hv   = 1'b1;
         end else if (rd && a == A_HEEP && bc == 3) m_hv = 1'b0;
      end
      if (wr && a == A_CLK) m_clk = write_data[4:0];
      if (wr && a == A_LED) m_led = write_data[0];
      if (wr && a == A_INSTR && bc < 4) m_instr[bc*8 +: 8] = write_data;
      if (wr && a == A_ADDR && bc < 4)  m_addr[bc*8 +: 8]  = write_data;
      m_rd = nrd;
   endtask

   always @(posedge usb_clk or posedge reset_i) begin
      if (reset_i) begin
         mq.delete();
         m_clk = '0; m_led = 1'b0; m_instr = '0; m_addr = '0;
         m_ovf = 1'b0; m_heep = '0; m_hv = 1'b0; m_rd = '0;
      end else begin
         model_step();
      end
   end

   // Compare process, away from the active edge
   always @(negedge usb_clk) begin
      check("cmd_valid",   O_cmd_valid,   mq.size() != 0);
      check("instruction", O_instruction, (mq.size() != 0) ? mq[0][31:0]  : 32'h0);
      check("address",     O_address,     (mq.size() != 0) ? mq[0][63:32] : 32'h0);
      check("status",      O_status,      model_status());
      check("clksettings", O_clksettings, m_clk);
      check("user_led",    O_user_led,    m_led);
      check("read_data",   read_data,     m_rd);
   end

   // ---------------- stimulus helpers (entered at posedge+2) ----------------
   task automatic wr_reg(input int a, input int bc, input logic [7:0] d);
      reg_address = AW'(a); reg_bytecnt = BC'(bc); write_data = d;
      reg_addrvalid = 1'b1; reg_write = 1'b1;
      @(posedge usb_clk); #2;
      reg_addrvalid = 1'b0; reg_write = 1'b0;
   endtask

   task automatic rd_reg(input int a, input int bc, output logic [7:0] d);
      reg_address = AW'(a); reg_bytecnt = BC'(bc);
      reg_addrvalid = 1'b1; reg_read = 1'b1;
      @(posedge usb_clk); #2;
      reg_addrvalid = 1'b0; reg_read = 1'b0;
      d = read_data;
   endtask

   task automatic stage_word(input int a, input logic [31:0] v);
      for (int i = 0; i < 4; i++) wr_reg(a, i, v[i*8 +: 8]);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge usb_clk);
      #2;
   endtask

   initial begin
      logic [7:0] b;
      logic [31:0] exp_word;
      exp_word = 32'hDEAD_BEEF;

      // Reset
      idle(3);
      check("reset_status", O_status, 8'h01);
      reset_i = 1'b0;
      idle(1);
      check("post_reset_valid", O_cmd_valid, 1'b0);

      // Clock settings and LED
      wr_reg(A_CLK, 0, 8'hF5);
      check("clk_lit", O_clksettings, 5'h15);
      wr_reg(A_LED, 0, 8'h03);
      check("led_lit", O_user_led, 1'b1);
      rd_reg(A_CLK, 0, b);
      check("clk_read_lit", b, 8'h15);
      rd_reg(A_BUILD, 0, b);
      check("build_read_lit", b, 8'h00);

      // Single command, bridge ready
      I_cmd_ready = 1'b1;
      stage_word(A_ADDR, 32'h0000_0180);
      stage_word(A_INSTR, 32'h0051_0513);
      wr_reg(A_INSTR, 5, 8'hAA);
      rd_reg(A_INSTR, 2, b);
      check("instr_byte2_lit", b, 8'h51);
      rd_reg(A_INSTR, 0, b);
      check("instr_byte0_lit", b, 8'h13);
      wr_reg(A_COMMIT, 0, 8'h00);
      check("single_valid_lit", O_cmd_valid, 1'b1);
      check("single_instr_lit", O_instruction, 32'h0051_0513);
      check("single_addr_lit", O_address, 32'h0000_0180);
      idle(1);
      check("single_popped_lit", O_cmd_valid, 1'b0);
      check("single_status_lit", O_status, 8'h01);

      // Five commits into a depth-4 FIFO with the bridge stalled
      I_cmd_ready = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         wr_reg(A_INSTR, 0, 8'(k));
         wr_reg(A_COMMIT, 0, 8'h00);
      end
      check("overflow_status_lit", O_status, 8'h46);
      wr_reg(A_STAT, 0, 8'h04);
      check("ovf_clear_lit", O_status, 8'h42);
      rd_reg(A_STAT, 0, b);
      check("status_read_lit", b, 8'h42);

      // Full FIFO: commit and pop in the same cycle
      wr_reg(A_INSTR, 0, 8'h06);
      I_cmd_ready = 1'b1;
      wr_reg(A_COMMIT, 0, 8'h00);
      I_cmd_ready = 1'b0;
      check("push_pop_full_lit", O_status, 8'h42);
      check("push_pop_head_lit", O_instruction, 32'h0051_0502);
      I_cmd_ready = 1'b1;
      idle(4);
      check("drain_status_lit", O_status, 8'h01);

      // Flush with three entries queued
      I_cmd_ready = 1'b0;
      repeat (3) wr_reg(A_COMMIT, 0, 8'h00);
      check("three_queued_lit", O_status, 8'h30);
      wr_reg(A_STAT, 0, 8'h80);
      check("flush_status_lit", O_status, 8'h01);
      check("flush_valid_lit", O_cmd_valid, 1'b0);

      // Readback shadow
      I_heep_data = 32'hDEAD_BEEF;
      I_heep_data_valid = 1'b1;
      idle(1);
      I_heep_data_valid = 1'b0;
      check("heep_flag_set", O_status[3], RB_EN);
      for (int i = 0; i < 4; i++) begin
         rd_reg(A_HEEP, i, b);
         check("heep_byte", b, RB_EN ? exp_word[i*8 +: 8] : 8'h00);
         if (i == 2) check("heep_flag_held", O_status[3], RB_EN);
      end
      check("heep_flag_cleared", O_status[3], 1'b0);
      I_heep_data_valid = 1'b1;
      rd_reg(A_HEEP, 3, b);
      I_heep_data_valid = 1'b0;
      check("heep_capture_wins", O_status[3], RB_EN);

      // Asynchronous reset with two commands queued
      repeat (2) wr_reg(A_COMMIT, 0, 8'h00);
      check("pre_reset_valid", O_cmd_valid, 1'b1);
      #1 reset_i = 1'b1;
      #1;
      check("async_valid_lit", O_cmd_valid, 1'b0);
      check("async_instr_lit", O_instruction, 32'h0);
      check("async_status_lit", O_status, 8'h01);
      idle(2);
      reset_i = 1'b0;
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
